// File: rtl/bram_cmd_responder_if.sv
// Command and BRAM-port bundle for bram_cmd_responder.
// The master side issues commands and models the BRAM; the slave side is the responder.
interface bram_cmd_responder_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                    run;
  logic                    mode;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   write_data;
  logic                    idle;
  logic                    done;
  logic [DATA_WIDTH-1:0]   read_data;
  logic                    read_valid;
  logic                    err;
  logic                    bram_en;
  logic [DATA_WIDTH/8-1:0] bram_we;
  logic [ADDR_WIDTH-1:0]   bram_addr;
  logic [DATA_WIDTH-1:0]   bram_din;
  logic [DATA_WIDTH-1:0]   bram_dout;

  modport slave (
    input  run, mode, addr, write_data, bram_dout,
    output idle, done, read_data, read_valid, err,
           bram_en, bram_we, bram_addr, bram_din
  );

  modport master (
    output run, mode, addr, write_data, bram_dout,
    input  idle, done, read_data, read_valid, err,
           bram_en, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/bram_cmd_responder.sv
// Single-command BRAM read/write responder: IDLE -> ACCESS -> (WAIT) -> DONE.
// Define BRAM_ADDR_ALIGN_CHECK_EN to reject word-misaligned addresses with err.
module bram_cmd_responder #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input logic                  system_clk,
  input logic                  reset,
  bram_cmd_responder_if.slave  bus
);

  localparam int BYTES = DATA_WIDTH / 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]            state;
  logic [1:0]            wait_cnt;
  logic                  mode_q;
  logic                  done_q;
  logic                  read_valid_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] read_data_q;
  logic                  bram_en_q;
  logic [BYTES-1:0]      bram_we_q;
  logic [ADDR_WIDTH-1:0] bram_addr_q;
  logic [DATA_WIDTH-1:0] bram_din_q;
  logic                  misaligned;

`ifdef BRAM_ADDR_ALIGN_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
  assign misaligned = (bus.addr & ALIGN_MASK) != '0;
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      mode_q       <= 1'b0;
      done_q       <= 1'b0;
      read_valid_q <= 1'b0;
      err_q        <= 1'b0;
      read_data_q  <= '0;
      bram_en_q    <= 1'b0;
      bram_we_q    <= '0;
      bram_addr_q  <= '0;
      bram_din_q   <= '0;
    end else begin
      // Pulses and BRAM strobes default low; each state raises them for one cycle.
      done_q       <= 1'b0;
      read_valid_q <= 1'b0;
      err_q        <= 1'b0;
      bram_en_q    <= 1'b0;
      bram_we_q    <= '0;
      case (state)
        IDLE: begin
          if (bus.run) begin
            mode_q <= bus.mode;
            if (misaligned) begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              state       <= ACCESS;
              bram_en_q   <= 1'b1;
              bram_we_q   <= bus.mode ? '1 : '0;
              bram_addr_q <= bus.addr;
              bram_din_q  <= bus.write_data;
            end
          end
        end
        ACCESS: begin
          wait_cnt <= '0;
          if (mode_q) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // The ACCESS edge is the BRAM enable edge; capture READ_LATENCY edges later.
          if (wait_cnt == 2'(READ_LATENCY - 1)) begin
            state        <= DONE;
            done_q       <= 1'b1;
            read_valid_q <= 1'b1;
            read_data_q  <= bus.bram_dout;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.idle       = (state == IDLE);
  assign bus.done       = done_q;
  assign bus.read_valid = read_valid_q;
  assign bus.err        = err_q;
  assign bus.read_data  = read_data_q;
  assign bus.bram_en    = bram_en_q;
  assign bus.bram_we    = bram_we_q;
  assign bus.bram_addr  = bram_addr_q;
  assign bus.bram_din   = bram_din_q;

endmodule

// File: doc/bram_cmd_responder.md
BRAM_CMD_RESPONDER -- requirements
Module: bram_cmd_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, meaning byte-address width of the command and BRAM address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width; a multiple of 8.
REQ-003 SHALL have parameter READ_LATENCY, default 1, meaning BRAM clocks from enable edge to valid bram_dout; legal values 1 and 2.
REQ-004 SHALL have port system_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port run  input  1  command request, sampled only while idle.
REQ-007 SHALL have port mode  input  1  1 = write, 0 = read.
REQ-008 SHALL have port addr  input  ADDR_WIDTH  byte address of the command.
REQ-009 SHALL have port write_data  input  DATA_WIDTH  write payload.
REQ-010 SHALL have port idle  output  1  high only in IDLE state.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port read_data  output  DATA_WIDTH  registered read result.
REQ-013 SHALL have port read_valid  output  1  one-cycle pulse marking new read_data.
REQ-014 SHALL have port err  output  1  one-cycle pulse with done for a rejected command.
REQ-015 SHALL have ports bram_en (1), bram_we (DATA_WIDTH/8), bram_addr (ADDR_WIDTH), bram_din (DATA_WIDTH) as outputs and bram_dout (DATA_WIDTH) as input, all registered outputs, driving one BRAM port.

Function
REQ-016 SHALL implement states IDLE, ACCESS, WAIT, DONE; IDLE->ACCESS on an edge with run=1; ACCESS->DONE for write; ACCESS->WAIT for read; WAIT->DONE after READ_LATENCY edges counted from the ACCESS edge; DONE->IDLE unconditionally.
REQ-017 SHALL latch mode, addr and write_data on the accepting edge; later input changes SHALL not affect the command in flight.
REQ-018 SHALL ignore run in every state other than IDLE; no queuing.
REQ-019 SHALL, in ACCESS, drive bram_en=1, bram_addr=latched addr, bram_din=latched data, bram_we=all ones for write and all zeros for read, for exactly one cycle; bram_en=0 and bram_we=0 at all other times.
REQ-020 SHALL, for write accepted at edge E0, assert done during the cycle after edge E1 (two edges after acceptance); read_valid stays 0 and read_data holds.
REQ-021 SHALL, for read accepted at E0, capture bram_dout into read_data at edge E(1+READ_LATENCY) and assert done and read_valid together for that following cycle.
REQ-022 SHALL hold read_data stable from capture until the next completed read.
REQ-023 SHALL drive idle=0 from the cycle after acceptance through the DONE cycle; idle=1 the cycle after done; a run asserted in that cycle SHALL be accepted.
REQ-024 SHALL treat addr as a byte address passed unchanged to bram_addr; no wrap or truncation beyond ADDR_WIDTH.

Reset
REQ-025 SHALL, on reset low, asynchronously force state=IDLE, idle=1, done=0, read_valid=0, err=0, read_data=0, bram_en=0, bram_we=0, bram_addr=0, bram_din=0.
REQ-026 SHALL abort any in-flight command on reset with no done pulse, and resume accepting run on the first edge after reset deasserts.

Configuration
REQ-027 SHALL, with macro BRAM_ADDR_ALIGN_CHECK_EN defined, reject a command whose addr low log2(DATA_WIDTH/8) bits are nonzero: no BRAM access (bram_en stays 0), state goes IDLE->DONE, done=1 and err=1 for one cycle, read_data unchanged, read_valid=0.
REQ-028 SHALL, without BRAM_ADDR_ALIGN_CHECK_EN, tie err to 0 and execute misaligned addresses unchanged.

Verification
REQ-029 SHALL cover: reset low 10 ns mid-read -> all outputs at reset values, idle=1, no done pulse after release.
REQ-030 SHALL cover: writes addr=4*i, data=i for i=0..9 -> bram_we=4'hF one cycle each, done 2 edges after each accept, read_valid=0.
REQ-031 SHALL cover: reads addr=4*i, i=1..9, BRAM model latency 1 -> read_data=i with read_valid=done=1 at edge 2 after accept; repeat with READ_LATENCY=2 -> edge 3.
REQ-032 SHALL cover: run held high during a read and back-to-back run in the cycle idle returns -> exactly one command per IDLE visit, second accepted immediately.
REQ-033 SHALL cover: with BRAM_ADDR_ALIGN_CHECK_EN, read addr=12'h006 -> err=done=1, bram_en never high, read_data unchanged; without the macro -> normal read from 12'h006, err=0.
